// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
// Module      : regfile_wb_arbiter_pkg
// Description : Shared register-file bus widths and writeback requester ids.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_wb_arbiter_pkg;

   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 64;
   localparam int RF_NUM_REGS = 32;

   typedef logic [RF_ADDR_W-1:0] reg_bus_t;
   typedef logic [RF_DATA_W-1:0] data_bus_t;

   localparam data_bus_t ZERO_64 = '0;

   // Requester slot order on the shared writeback port.
   localparam int WB_REQ_ALU = 0;
   localparam int WB_REQ_LSU = 1;
   localparam int WB_REQ_CSR = 2;
   localparam int WB_NUM_REQ = 3;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with one-hot grant and rotating pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import regfile_wb_arbiter_pkg::*;

module rr_arbiter #(
   parameter  int N  = WB_NUM_REQ,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic          w_found;

   // Search starts at the pointer and wraps, so the last winner has lowest priority.
   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (int'(r_ptr) + k) % N;
         if (!w_found && req[j]) begin
            w_found  = 1'b1;
            grant[j] = 1'b1;
            w_idx    = PW'(j);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (advance && w_found) begin
         r_ptr <= (w_idx == PW'(N-1)) ? '0 : w_idx + 1'b1;
      end
   end

   assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the regfile write port among writeback sources and
//               tracks pending writes for decode read-after-write stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
   parameter int NUM_REQ  = WB_NUM_REQ,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic                      rf_wen,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   input  logic                      issue_valid,
   input  logic [ADDR_W-1:0]         issue_addr,
   input  logic                      chk_a_en,
   input  logic [ADDR_W-1:0]         chk_a_addr,
   input  logic                      chk_b_en,
   input  logic [ADDR_W-1:0]         chk_b_addr,
   output logic                      stall,
   output logic [NUM_REGS-1:0]       busy_vec
);

   localparam int              c_ptr_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W:0] c_num_regs = NUM_REGS[ADDR_W:0];

   logic [NUM_REQ-1:0]  w_grant;
   logic [c_ptr_w-1:0]  w_rr_ptr;
   logic                w_xfer;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_data;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_hz_a;
   logic                w_hz_b;

   logic                r_wen;
   logic [ADDR_W-1:0]   r_waddr;
   logic [DATA_W-1:0]   r_wdata;
   logic [NUM_REGS-1:0] r_busy;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (rst),
      .grant   (w_grant),
      .ptr     (w_rr_ptr)
   );

   // Nothing is granted while reset is held.
   assign req_ready = rst ? w_grant : '0;
   assign w_xfer    = |req_ready;

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_wen <= w_xfer && (w_sel_addr != '0);
         if (w_xfer) begin
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
         end
      end
   end

   // Set after clear: a fresh issue to the register being retired stays pending.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_wen) begin
         w_busy_nxt[r_waddr] = 1'b0;
      end
      if (issue_valid && (issue_addr != '0)) begin
         w_busy_nxt[issue_addr] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // The regfile bypasses its write port to reads, so an in-flight write clears the hazard.
   assign w_hz_a = r_busy[chk_a_addr] && (chk_a_addr != '0) &&
                   !(r_wen && (r_waddr == chk_a_addr));
   assign w_hz_b = r_busy[chk_b_addr] && (chk_b_addr != '0) &&
                   !(r_wen && (r_waddr == chk_b_addr));

   assign stall    = (chk_a_en && w_hz_a) || (chk_b_en && w_hz_b);
   assign rf_wen   = r_wen;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;
   assign busy_vec = r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         assert (int'(w_rr_ptr) < NUM_REQ);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
               assert ({1'b0, req_addr[i*ADDR_W +: ADDR_W]} < c_num_regs);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

   localparam int NUM_REQ  = 3;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 64;
   localparam int NUM_REGS = 32;

   localparam logic [63:0] c_data_a = 64'hAAAA_0000_0000_0001;
   localparam logic [63:0] c_data_b = 64'hBBBB_0000_0000_0002;
   localparam logic [63:0] c_data_c = 64'hCCCC_0000_0000_0003;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      rf_wen;
   logic [ADDR_W-1:0]         rf_waddr;
   logic [DATA_W-1:0]         rf_wdata;
   logic                      issue_valid;
   logic [ADDR_W-1:0]         issue_addr;
   logic                      chk_a_en;
   logic [ADDR_W-1:0]         chk_a_addr;
   logic                      chk_b_en;
   logic [ADDR_W-1:0]         chk_b_addr;
   logic                      stall;
   logic [NUM_REGS-1:0]       busy_vec;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   regfile_wb_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .chk_a_en    (chk_a_en),
      .chk_a_addr  (chk_a_addr),
      .chk_b_en    (chk_b_en),
      .chk_b_addr  (chk_b_addr),
      .stall       (stall),
      .busy_vec    (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   // Advance one clock and land on the following falling edge.
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst         = 1'b0;
      req_valid   = 3'b111;
      req_addr    = '0;
      req_data    = '0;
      issue_valid = 1'b1;
      issue_addr  = 5'd3;
      chk_a_en    = 1'b0;
      chk_a_addr  = '0;
      chk_b_en    = 1'b0;
      chk_b_addr  = '0;
      set_req(0, 5'd1, c_data_a);
      set_req(1, 5'd2, c_data_b);
      set_req(2, 5'd3, c_data_c);

      // Reset held with every requester valid.
      #1;
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_wen", 64'(rf_wen), 64'h0);
      check("rst_busy", 64'(busy_vec), 64'h0);
      tick();
      check("rst_ready_clk", 64'(req_ready), 64'h0);
      check("rst_wen_clk", 64'(rf_wen), 64'h0);
      check("rst_waddr", 64'(rf_waddr), 64'h0);
      check("rst_wdata", rf_wdata, 64'h0);
      check("rst_busy_clk", 64'(busy_vec), 64'h0);

      // Round-robin: 0, 1, 2 back to back.
      rst         = 1'b1;
      issue_valid = 1'b0;
      #1;
      check("rr_grant0", 64'(req_ready), 64'b001);
      tick();
      req_valid = 3'b110;
      #1;
      check("rr_wen0", 64'(rf_wen), 64'h1);
      check("rr_waddr0", 64'(rf_waddr), 64'd1);
      check("rr_wdata0", rf_wdata, c_data_a);
      check("rr_grant1", 64'(req_ready), 64'b010);
      tick();
      req_valid = 3'b100;
      #1;
      check("rr_waddr1", 64'(rf_waddr), 64'd2);
      check("rr_wdata1", rf_wdata, c_data_b);
      check("rr_grant2", 64'(req_ready), 64'b100);
      tick();
      req_valid = 3'b000;
      #1;
      check("rr_wen2", 64'(rf_wen), 64'h1);
      check("rr_waddr2", 64'(rf_waddr), 64'd3);
      check("rr_wdata2", rf_wdata, c_data_c);
      check("rr_idle_ready", 64'(req_ready), 64'h0);
      tick();
      check("rr_idle_wen", 64'(rf_wen), 64'h0);

      // Write to x0 is granted but never reaches the regfile.
      set_req(1, 5'd0, 64'hDEAD);
      req_valid = 3'b010;
      #1;
      check("x0_ready", 64'(req_ready), 64'b010);
      tick();
      req_valid = 3'b000;
      #1;
      check("x0_wen", 64'(rf_wen), 64'h0);
      check("x0_busy", 64'(busy_vec), 64'h0);

      // Pointer sits at 2 with only 0 and 1 valid: wrap to 0 first.
      set_req(0, 5'd4, 64'h44);
      set_req(1, 5'd6, 64'h66);
      req_valid = 3'b011;
      #1;
      check("wrap_grant0", 64'(req_ready), 64'b001);
      tick();
      req_valid = 3'b010;
      #1;
      check("wrap_waddr0", 64'(rf_waddr), 64'd4);
      check("wrap_grant1", 64'(req_ready), 64'b010);
      tick();
      req_valid = 3'b000;
      #1;
      check("wrap_waddr1", 64'(rf_waddr), 64'd6);
      check("wrap_wdata1", rf_wdata, 64'h66);

      // Hazard on x5, resolved by an LSU write.
      issue_valid = 1'b1;
      issue_addr  = 5'd5;
      tick();
      issue_valid = 1'b0;
      chk_a_en    = 1'b1;
      chk_a_addr  = 5'd5;
      #1;
      check("hz_busy_set", 64'(busy_vec), 64'h20);
      check("hz_stall", 64'(stall), 64'h1);
      set_req(1, 5'd5, 64'h55);
      req_valid = 3'b010;
      #1;
      check("hz_lsu_ready", 64'(req_ready), 64'b010);
      check("hz_stall_pre", 64'(stall), 64'h1);
      tick();
      req_valid = 3'b000;
      #1;
      check("hz_wen", 64'(rf_wen), 64'h1);
      check("hz_stall_bypass", 64'(stall), 64'h0);
      check("hz_busy_still", 64'(busy_vec), 64'h20);
      tick();
      check("hz_busy_clear", 64'(busy_vec), 64'h0);
      check("hz_stall_clear", 64'(stall), 64'h0);
      chk_a_en = 1'b0;

      // Set-wins: issue x7 in the same cycle x7 is written back.
      set_req(2, 5'd7, 64'h77);
      req_valid = 3'b100;
      #1;
      check("sw_csr_ready", 64'(req_ready), 64'b100);
      tick();
      req_valid   = 3'b000;
      issue_valid = 1'b1;
      issue_addr  = 5'd7;
      chk_b_en    = 1'b1;
      chk_b_addr  = 5'd7;
      #1;
      check("sw_wen", 64'(rf_wen), 64'h1);
      check("sw_waddr", 64'(rf_waddr), 64'd7);
      check("sw_stall_pre", 64'(stall), 64'h0);
      tick();
      issue_valid = 1'b0;
      #1;
      check("sw_busy", 64'(busy_vec), 64'h80);
      check("sw_stall", 64'(stall), 64'h1);
      chk_b_en = 1'b0;
      #1;
      check("sw_stall_off", 64'(stall), 64'h0);

      // Asynchronous reset in the middle of a write.
      set_req(0, 5'd9, 64'h99);
      req_valid = 3'b001;
      #1;
      check("ar_grant", 64'(req_ready), 64'b001);
      tick();
      req_valid = 3'b000;
      #1;
      check("ar_wen_before", 64'(rf_wen), 64'h1);
      check("ar_waddr_before", 64'(rf_waddr), 64'd9);
      #1;
      rst = 1'b0;
      #1;
      check("ar_wen", 64'(rf_wen), 64'h0);
      check("ar_waddr", 64'(rf_waddr), 64'h0);
      check("ar_wdata", rf_wdata, 64'h0);
      check("ar_busy", 64'(busy_vec), 64'h0);
      tick();
      rst       = 1'b1;
      req_valid = 3'b101;
      #1;
      check("ar_ptr_reset", 64'(req_ready), 64'b001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (Rw_en/Rw_addr/Rw) between NUM_REQ writeback sources (ALU, load unit, CSR unit).
- Keeps a per-register pending-write scoreboard so decode can stall reads of registers that are not yet written back.
- Sits between the execute/memory writeback paths and Regfile. Its rf_* outputs drive the Regfile write port directly.

Parameters:
NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = CSR)
ADDR_W, 5, register address width
DATA_W, 64, register data width
NUM_REGS, 32, architectural registers; x0 hardwired zero

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
req_valid  input  NUM_REQ  per-requester writeback request
req_ready  output  NUM_REQ  per-requester grant; transfer when valid&ready
req_addr  input  NUM_REQ*ADDR_W  packed destination register, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed writeback data
rf_wen  output  1  to Regfile Rw_en (registered)
rf_waddr  output  ADDR_W  to Regfile Rw_addr (registered)
rf_wdata  output  DATA_W  to Regfile Rw (registered)
issue_valid  input  1  decode issued an instruction that will write issue_addr
issue_addr  input  ADDR_W  destination of issued instruction
chk_a_en  input  1  decode reads chk_a_addr
chk_a_addr  input  ADDR_W  source A
chk_b_en  input  1  decode reads chk_b_addr
chk_b_addr  input  ADDR_W  source B
stall  output  1  read-after-write hazard, hold decode
busy_vec  output  NUM_REGS  scoreboard state, debug/difftest

Behaviour:
- Reset (rst=0, asynchronous): rf_wen=0, rf_waddr=0, rf_wdata=0, busy_vec=0, round-robin pointer=0. All in-flight requests are dropped.
- Arbitration:
  - Round-robin over requesters with req_valid=1, starting at the pointer.
  - req_ready is combinational: exactly one bit set, for the winner, and only if any valid is set; otherwise all zero.
  - A requester must hold valid/addr/data stable until ready.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Write latency: the granted transfer appears on rf_* exactly 1 cycle later, for one cycle.
  - rf_wen=1 only if the granted addr != 0.
  - A granted write to x0 is accepted (ready=1) but produces rf_wen=0, so nothing is written.
- Scoreboard:
  - issue_valid with issue_addr!=0 sets busy[issue_addr] at the clock edge.
  - rf_wen=1 clears busy[rf_waddr] at the clock edge.
  - Same register set and cleared in the same cycle: set wins (the newer producer stays pending).
  - busy[0] is always 0.
- Stall (combinational): stall = (chk_a_en & hz(chk_a_addr)) | (chk_b_en & hz(chk_b_addr)).
  - hz(r) = busy[r] & (r!=0) & !(rf_wen & rf_waddr==r).
  - A register being written this cycle does not stall, because Regfile bypasses Rw to the reads.
- Width: addresses are unsigned. A packed slice whose index is >= NUM_REGS is a requester error; its behaviour is undefined and covered by an assertion.
- Back-to-back grants every cycle are required: full throughput, no bubble.

Decomposition:
- Shared header defines.v: REG_BUS, DATA_BUS, ZERO_64 (existing), plus new constants: WB_REQ_ALU=0, WB_REQ_LSU=1, WB_REQ_CSR=2, WB_NUM_REQ=3.
- One sub-module, rr_arbiter: parameter N; inputs req[N] and advance; outputs a one-hot grant[N] and the internal pointer, with the asynchronous active-low reset.
- Scoreboard, output registers and stall logic stay in regfile_wb_arbiter.

Test Plan:
- Reset: hold rst=0 with all req_valid=1 -> req_ready=000, rf_wen=0, busy_vec=0. Release -> the first grant goes to requester 0.
- Round-robin: req_valid=111 for 3 cycles, addrs 1/2/3, data A/B/C -> grants 0,1,2 on consecutive cycles; rf_wen=1 with (1,A),(2,B),(3,C) one cycle after each grant.
- x0 write: requester 1 valid, addr 0, data 0xDEAD -> ready=010; next cycle rf_wen=0 and busy_vec unchanged.
- Hazard: issue x5, then chk_a_addr=5 -> stall=1. LSU writes x5 -> stall=0 in the rf_wen cycle; busy[5]=0 the cycle after.
- Set-wins: issue x7 in the same cycle rf_wen writes x7 -> busy[7] stays 1; chk_b_addr=7 next cycle -> stall=1.
- Async reset mid-grant: assert rst=0 between clock edges while rf_wen=1 -> rf_wen drops to 0 immediately and busy_vec clears.
